// File: rtl/dmem_defs.sv
// Shared definitions for the data-memory responder: FSM encodings, counter width,
// captured-request layout and address error decode.
package dmem_defs;

  localparam int unsigned CntWidth = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // Misaligned or beyond the last word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables and registered read.
// Contents are never reset.
module dmem_array
  import dmem_defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AddrWidth   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [AddrWidth-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: req/ack handshake with LATENCY wait states.
// Define DMEM_BYTE_EN to add the be port and per-byte write masking.
module dmem_responder
  import dmem_defs::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AddrWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CntWidth-1:0] LatCnt = CntWidth'(LATENCY);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  dmem_req_t           req_in, req_q, cur;
  logic                cur_err;
  logic                go_resp;
  logic                zero_q;
  logic                ram_en, ram_we;
  logic [31:0]         ram_rdata;

  always_comb begin
    req_in.we    = we;
    req_in.addr  = addr;
    req_in.wdata = wdata;
`ifdef DMEM_BYTE_EN
    req_in.be    = be;
`else
    req_in.be    = 4'b1111;
`endif
  end

  // With zero latency the RAM read is issued on the capture edge, so use the live inputs.
  assign cur     = (state_q == StIdle) ? req_in : req_q;
  assign cur_err = addr_err(cur.addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = LatCnt;
          if (LATENCY == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntWidth'(1);
        if (cnt_q == CntWidth'(1)) begin
          state_d = StResp;
          go_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) req_q <= req_in;
      // rdata is forced to 0 after an errored response and released by the next good read.
      if (go_resp) begin
        if (cur_err) zero_q <= 1'b1;
        else if (!cur.we) zero_q <= 1'b0;
      end
    end
  end

  assign ram_we = (state_q == StResp) && req_q.we && !cur_err;
  assign ram_en = ram_we || (go_resp && !cur.we && !cur_err);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AddrWidth  (AddrWidth)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (req_q.be),
    .addr (cur.addr[AddrWidth+1:2]),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  assign rdata = zero_q ? 32'h0 : ram_rdata;
  assign ack   = (state_q == StResp);
  assign err   = ack && cur_err;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level memory model checked every cycle,
// directed vectors with literal expectations. DMEM_BYTE_EN adds byte-enable vectors.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = 4'hF;
  logic [31:0] rdata;
  logic        ack, err, busy;

  logic        req_z = 1'b0, we_z = 1'b0;
  logic [31:0] addr_z = '0, wdata_z = '0;
  logic [31:0] rdata_z;
  logic        ack_z, err_z, busy_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_EN
    .be(be),
`endif
    .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
`ifdef DMEM_BYTE_EN
    .be(4'hF),
`endif
    .rdata(rdata_z), .ack(ack_z), .err(err_z), .busy(busy_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // Transaction-level model: a request is accepted whenever no transaction is open,
  // acknowledged LAT edges later, and its write lands on the following edge.
  int          m_e = 0, m_cap = 0;
  bit          m_act = 1'b0, m_was;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] mem_m [int];
  logic [31:0] rd_exp = '0;
  bit          rd_known = 1'b1;
  logic        exp_ack;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_act = 1'b0;
    end else begin
      m_was = m_act;
      m_e++;
      if (m_act && m_e == m_cap + LAT + 1) begin
        if (m_we && !bad_addr(m_addr)) begin
          logic [31:0] w;
          w = mem_m.exists(int'(m_addr >> 2)) ? mem_m[int'(m_addr >> 2)] : 32'h0;
          for (int i = 0; i < 4; i++) if (m_be[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
          mem_m[int'(m_addr >> 2)] = w;
        end
        m_act = 1'b0;
      end
      if (!m_was && req) begin
        m_act = 1'b1; m_cap = m_e;
        m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    exp_ack = rst && m_act && (m_e == m_cap + LAT);
    if (!rst) begin
      rd_exp = '0; rd_known = 1'b1;
    end else if (exp_ack) begin
      if (bad_addr(m_addr)) begin
        rd_exp = '0; rd_known = 1'b1;
      end else if (!m_we) begin
        rd_known = mem_m.exists(int'(m_addr >> 2));
        if (rd_known) rd_exp = mem_m[int'(m_addr >> 2)];
      end
    end
    check1("ack", ack, exp_ack);
    check1("busy", busy, m_act);
    if (exp_ack) check1("err", err, bad_addr(m_addr));
    if (rd_known) check("rdata", rdata, rd_exp);
  end

  // Call at posedge+1 with the DUT idle; returns edges from request to ack.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int lat, output logic [31:0] rd,
                     output logic e);
    bit got;
    got = 1'b0; lat = 0; rd = '0; e = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1; lat = i; rd = rdata; e = err;
      end
    end
    req = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: no ack within 50 cycles for addr 0x%08h", a);
    end
    @(posedge clk); #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        e;
  logic [4:0]  pat_z = 5'b00101;
  bit          got_z;

  initial begin
    repeat (3) @(negedge clk);
    check1("rst_ack", ack, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    txn(1'b1, 32'h0, 32'h1111_1111, 4'hF, lat, rd, e);
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, e);
    check("wr_lat", lat, 3);
    check1("wr_err", e, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check1("rd_err", e, 1'b0);
    check("model_rd", rd_exp, 32'hDEAD_BEEF);

    txn(1'b0, 32'h13, 32'h0, 4'hF, lat, rd, e);
    check1("mis_err", e, 1'b1);
    check("mis_data", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
    check("after_mis", rd, 32'hDEAD_BEEF);

    txn(1'b1, 32'h1000, 32'h1234_5678, 4'hF, lat, rd, e);
    check1("oob_wr_err", e, 1'b1);
    check1("model_oob", mem_m.exists(1024), 1'b0);
    txn(1'b0, 32'h0, 32'h0, 4'hF, lat, rd, e);
    check("oob_keep0", rd, 32'h1111_1111);
    txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
    check("oob_keep10", rd, 32'hDEAD_BEEF);

    txn(1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF, lat, rd, e);
    check1("last_wr_err", e, 1'b0);
    txn(1'b0, 32'hFFC, 32'h0, 4'hF, lat, rd, e);
    check("last_rd", rd, 32'h0BAD_F00D);
    txn(1'b0, 32'h1000, 32'h0, 4'hF, lat, rd, e);
    check1("oob_rd_err", e, 1'b1);
    check("oob_rd_data", rd, 32'h0);
    txn(1'b1, 32'h14, 32'h55AA_55AA, 4'hF, lat, rd, e);
    txn(1'b0, 32'h14, 32'h0, 4'hF, lat, rd, e);
    check("raw_rd", rd, 32'h55AA_55AA);

    // Reset while the write of 0xCAFEF00D sits in its wait states.
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFE_F00D; be = 4'hF;
    @(posedge clk); #1;
    check1("rst_mid_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    #1;
    check1("rst_mid_ack", ack, 1'b0);
    check1("rst_mid_busy0", busy, 1'b0);
    check("rst_mid_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
    check("post_rst_rd", rd, 32'hDEAD_BEEF);

`ifdef DMEM_BYTE_EN
    txn(1'b1, 32'h10, 32'h0000_AB00, 4'b0010, lat, rd, e);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
    check("be_rd", rd, 32'hDEAD_ABEF);
    txn(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, lat, rd, e);
    check1("be0_err", e, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e);
    check("be0_rd", rd, 32'hDEAD_ABEF);
`endif

    // Zero-latency instance: seed a word, then hold req high across two reads.
    req_z = 1'b1; we_z = 1'b1; addr_z = 32'h10; wdata_z = 32'hA5A5_A5A5;
    got_z = 1'b0;
    for (int i = 0; i < 20 && !got_z; i++) begin
      @(posedge clk); #1;
      if (ack_z) got_z = 1'b1;
    end
    req_z = 1'b0;
    if (!got_z) begin
      n_cmp++; n_bad++;
      $display("FAIL z_timeout: no ack from zero-latency instance");
    end
    @(posedge clk); #1;
    we_z = 1'b0; req_z = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check1("z_ack", ack_z, pat_z[k]);
      check1("z_busy", busy_z, pat_z[k]);
      check("z_rdata", rdata_z, 32'hA5A5_A5A5);
      if (pat_z[k]) check1("z_err", err_z, 1'b0);
      if (k == 2) req_z = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor's load/store port. It accepts one word-wide read or write request at a time over a req/ack handshake, inserts a parameterised number of wait states, and commits the write or returns read data. It sits between the CPU's memory-interface adapter (`aluout`/`writedata`/`MemWrite`) and its `readdata` input, and is used to model and exercise multi-cycle memory.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; the address range is 0 .. 4*DEPTH_WORDS-1.
- `LATENCY`, default 2: wait-state cycles between request capture and response. The legal range is 0..15.
- `clk` (input, 1): the single clock, rising edge.
- `rst` (input, 1): reset, asynchronous assert, active-low.
- `req` (input, 1): request valid. The requester holds it high until `ack`.
- `we` (input, 1): 1 selects a write, 0 selects a read. Sampled with `req`.
- `addr` (input, 32): byte address. Sampled with `req`.
- `wdata` (input, 32): write data. Sampled with `req`.
- `be` (input, 4): byte enables. Present only under `DMEM_BYTE_EN`.
- `rdata` (output, 32): read data. Valid in the `ack` cycle and held until the next `ack`.
- `ack` (output, 1): one-cycle response pulse.
- `err` (output, 1): error flag, valid only with `ack`.
- `busy` (output, 1): high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With `req`=1, capture `we`, `addr`, `wdata` (and `be`).
  - Load `cnt` with `LATENCY`.
  - Go to WAIT if `LATENCY`>0; otherwise go to RESP.
- WAIT:
  - Decrement `cnt`.
  - When `cnt`==1 at the clock edge, go to RESP.
  - Input changes are ignored here; only the captured copy is used.
- RESP:
  - Drive `ack`=1 for exactly one cycle, then return to IDLE.
  - A write commits to the array at the clock edge that ends RESP.
  - For a read, `rdata` is the array word at `addr[31:2]`, registered so it is valid during RESP.
- Error cases:
  - `addr[1:0]`≠0 gives `err`=1.
  - `addr[31:2]`≥`DEPTH_WORDS` gives `err`=1.
  - On error: the write is suppressed and `rdata` is driven to 0 for that response.
- `req` seen high in RESP is not a new request. If `req` is still high in the following IDLE cycle, it is captured as a new request.
- Throughput is one transaction per `LATENCY`+2 cycles.
- Read-after-write to the same word in the next transaction returns the new data.

## Timing
- Reset values: `ack`=0, `err`=0, `busy`=0, `rdata`=0, state IDLE, `cnt`=0. Array contents are not initialised and are retained across reset.
- Latency: `req` sampled at edge N gives `ack` high during cycle N+`LATENCY`+1.
- `busy` rises in the cycle after capture and falls in the cycle after `ack`.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, no `ack` is issued, and the pending write is dropped.
- `req` deasserted before `ack` is a protocol violation. The transaction completes regardless.

## Configuration
- `DMEM_BYTE_EN` defined:
  - The `be` port exists and each byte lane is written only when its enable bit is 1.
  - A write with `be`=0 completes with `ack` and changes no data.
  - Reads ignore `be` and return the full word.
- `DMEM_BYTE_EN` undefined: the port is absent and every write updates the full word.

## Structure
- Shared package/header `dmem_defs`: state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the width of `cnt` (4).
- Sub-module `dmem_array`:
  - Synchronous single-port RAM, `DEPTH_WORDS`×32.
  - Per-byte write enable, tied to 4'b1111 when `DMEM_BYTE_EN` is undefined.
  - Registered read.
- The top level contains the FSM, wait counter, request capture register and error decode.

## Test plan
- `LATENCY`=2: write 0xDEADBEEF to 0x10, then read 0x10. Each `ack` arrives 3 cycles after `req` capture with `err`=0; the read returns `rdata`=0xDEADBEEF.
- Read at misaligned address 0x13: `ack` with `err`=1 and `rdata`=0. A later read of 0x10 still returns 0xDEADBEEF.
- Write 0x12345678 to 0x1000 with `DEPTH_WORDS`=1024: `err`=1 and no array word changes. Check by reading 0x0 and 0x10, which must be unchanged.
- Reset asserted in WAIT during a write of 0xCAFEF00D to 0x10: `ack` never pulses and outputs return to reset values. A post-reset read of 0x10 returns 0xDEADBEEF.
- `DMEM_BYTE_EN`: write 0x0000AB00 with `be`=4'b0010 over 0xDEADBEEF at 0x10. A read then returns 0xDEADABEF.
- `LATENCY`=0 with `req` held high across two reads: `ack` pulses in cycles 1 and 3 after the first capture, and `busy` toggles accordingly.
